// File: rtl/cpu_fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM state
// encoding and the default post-reset fetch address.
package cpu_fetch_pkg;

  // Bus-side fetch FSM: IDLE drives no strobe, READ holds r and address_bus.
  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } fetch_state_e;

  // Default fetch address after reset; also used by the core's reset logic.
  localparam logic [15:0] DEFAULT_RESET_PC = 16'h2000;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO holding {instruction word, start pc} entries.
// flush empties the queue without touching storage; reset also loads every
// entry with RESET_VAL so the head presents a defined value out of reset.
module fetch_queue #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int              CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop, full;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A pop on an empty queue is ignored; a push into a full queue is only
  // accepted when a pop frees a slot on the same edge.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);

  // Next pointer/count values; flush wins over push and pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop) begin
        rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      if (do_push) begin
        wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/count registers and entry storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RESET_VAL;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (do_push && !flush_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
    end
  end

endmodule

// File: rtl/cpu_fetch_unit.sv
// Instruction-fetch front end: reads bytes from a byte-wide memory bus,
// assembles them into WORD_BYTES-byte instruction words tagged with their
// start address, and buffers them in a prefetch queue for the decoder.
// Handshake: the decoder takes the head word on any edge where
// instr_valid && instr_ready; on the bus side a byte is taken on an edge
// where r && bus_ready, and bus_ready low simply stretches the read.
module cpu_fetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 16,
  parameter int                WORD_BYTES  = 2,
  parameter int                QUEUE_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic [ADDR_W-1:0]            address_bus,
  input  logic [DATA_W-1:0]            data_bus_in,
  output logic                         r,
  input  logic                         bus_ready,
  input  logic                         halt,
  input  logic                         redirect,
  input  logic [ADDR_W-1:0]            redirect_pc,
  output logic                         instr_valid,
  output logic [DATA_W*WORD_BYTES-1:0] instr_word,
  output logic [ADDR_W-1:0]            instr_pc,
  input  logic                         instr_ready,
  output logic [ADDR_W-1:0]            fetch_pc
);

  localparam int WORD_W  = DATA_W * WORD_BYTES;
  localparam int ENTRY_W = WORD_W + ADDR_W;
  localparam int IDX_W   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int CNT_W   = $clog2(QUEUE_DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [ADDR_W-1:0] wpc_q, wpc_d;

  logic               q_push, q_pop, q_flush, q_empty, q_full;
  logic [CNT_W-1:0]   q_count;
  logic [ENTRY_W-1:0] q_head;

  assign address_bus = addr_q;
  assign fetch_pc    = pc_q;
  assign r           = (state_q == READ);
  assign instr_valid = !q_empty;
  assign instr_word  = q_head[ENTRY_W-1:ADDR_W];
  assign instr_pc    = q_head[ADDR_W-1:0];
  assign q_full      = (q_count >= CNT_W'(QUEUE_DEPTH));
  assign q_pop       = instr_valid && instr_ready;

  // Next-state logic: redirect first, then start a read or capture a byte.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pc_d    = pc_q;
    idx_d   = idx_q;
    word_d  = word_q;
    wpc_d   = wpc_q;
    q_push  = 1'b0;
    q_flush = 1'b0;
    if (redirect) begin
      state_d = IDLE;
      pc_d    = redirect_pc;
      idx_d   = '0;
      q_flush = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          // A word in progress always finishes; a new word needs a free slot.
          if (!halt && (idx_q != '0 || !q_full)) begin
            state_d = READ;
            addr_d  = pc_q;
          end
        end
        READ: begin
          if (bus_ready) begin
            word_d[idx_q*DATA_W +: DATA_W] = data_bus_in;
            if (idx_q == '0) begin
              wpc_d = addr_q;
            end
            pc_d    = pc_q + ADDR_W'(1);
            state_d = IDLE;
            if (idx_q == LAST_IDX) begin
              q_push = 1'b1;
              idx_d  = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM, bus address, PC and word-assembly registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= RESET_PC;
      pc_q    <= RESET_PC;
      idx_q   <= '0;
      word_q  <= '0;
      wpc_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      wpc_q   <= wpc_d;
    end
  end

  fetch_queue #(
    .WIDTH     (ENTRY_W),
    .DEPTH     (QUEUE_DEPTH),
    .RESET_VAL ({{WORD_W{1'b0}}, RESET_PC})
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .push_i      (q_push),
    .push_data_i ({word_d, wpc_d}),
    .pop_i       (q_pop),
    .flush_i     (q_flush),
    .count_o     (q_count),
    .empty_o     (q_empty),
    .head_o      (q_head)
  );

endmodule
